// File: rtl/csel_fork_sync.sv
// csel_fork_sync: latches a per-channel valid vector and forwards one token to the selected
// channels after DRIVE_DELAY cycles. Optional WAIT_FREE timeout: define CSEL_TIMEOUT_EN.
module csel_fork_sync #(
   parameter int unsigned NUM_CH         = 6,
   parameter int unsigned MODE           = 0,
   parameter int unsigned DRIVE_DELAY    = 8,
   parameter int unsigned JOIN_ALL       = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_drive,
   output logic              o_free,
   output logic              o_fire,
   input  logic [NUM_CH-1:0] i_valid,
   output logic [NUM_CH-1:0] o_driveNext,
   input  logic [NUM_CH-1:0] i_freeNext,
   output logic              o_drop,
   output logic              o_timeout
);
   localparam int unsigned PW = $clog2(NUM_CH);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WAIT_FREE} state_e;

   state_e            state_q;
   logic [NUM_CH-1:0] sel_q, sel_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] drive_q;
   logic [7:0]        cnt_q;
   logic [PW-1:0]     rr_q, rr_d;
   logic [PW-1:0]     idx;
   int unsigned       sum;
   logic              fire_q, drop_q, found, done;

`ifdef CSEL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wcnt_q;
   logic          timeout_q;
   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   assign o_free      = (state_q == S_IDLE);
   assign o_fire      = fire_q;
   assign o_drop      = drop_q;
   assign o_driveNext = drive_q;

   // Priority scan; round-robin starts the scan at rr_q and wraps.
   always_comb begin
      sel_d = '0;
      rr_d  = rr_q;
      found = 1'b0;
      sum   = 0;
      idx   = '0;
      if (MODE == 0) begin
         sel_d = i_valid;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum = (MODE == 2) ? 32'(rr_q) + i : i;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            idx = PW'(sum);
            if (!found && i_valid[idx]) begin
               found      = 1'b1;
               sel_d[idx] = 1'b1;
               rr_d       = (sum == NUM_CH - 1) ? '0 : PW'(sum + 1);
            end
         end
      end
   end

   always_comb begin
      pending_d = pending_q & ~i_freeNext;
      if (JOIN_ALL != 0) done = (pending_d == '0);
      else               done = |(i_freeNext & pending_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         pending_q <= '0;
         drive_q   <= '0;
         cnt_q     <= '0;
         rr_q      <= '0;
         fire_q    <= 1'b0;
         drop_q    <= 1'b0;
`ifdef CSEL_TIMEOUT_EN
         wcnt_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         fire_q  <= 1'b0;
         drop_q  <= 1'b0;
         drive_q <= '0;
`ifdef CSEL_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (i_drive) begin
                  sel_q  <= sel_d;
                  fire_q <= 1'b1;
                  if (sel_d == '0) begin
                     drop_q <= 1'b1;
                  end else begin
                     state_q <= S_DELAY;
                     cnt_q   <= 8'(DRIVE_DELAY);
                     if (MODE == 2) rr_q <= rr_d;
                  end
               end
            end
            S_DELAY: begin
               if (cnt_q == '0) begin
                  state_q   <= S_WAIT_FREE;
                  drive_q   <= sel_q;
                  pending_q <= sel_q;
`ifdef CSEL_TIMEOUT_EN
                  wcnt_q    <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            S_WAIT_FREE: begin
               if (done) begin
                  state_q   <= S_IDLE;
                  pending_q <= '0;
`ifdef CSEL_TIMEOUT_EN
               end else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  // Completion in the same cycle wins over the abort (checked above).
                  state_q   <= S_IDLE;
                  pending_q <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  pending_q <= pending_d;
                  wcnt_q    <= wcnt_q + TW'(1);
               end
`else
               end else begin
                  pending_q <= pending_d;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/csel_fork_sync.md
Name: csel_fork_sync

Overview:
- Clocked, parametrised successor of the six-way conditional-fork selector in the cache control path.
- Takes one drive token, latches a per-channel valid vector, and forwards the token after a programmable delay to one or all valid channels.
- Selection is broadcast, fixed-priority or round-robin; completion is any-free or all-free.
- Sits between the cache request stage and the per-way/per-port consumers; the fixed 8-unit delay element becomes a cycle counter.

Parameters:
- NUM_CH, 6, number of output channels (2..16).
- MODE, 0, selection: 0 broadcast to all valid, 1 lowest-index valid only, 2 round-robin among valid.
- DRIVE_DELAY, 8, cycles from o_fire to o_driveNext (0..255).
- JOIN_ALL, 0, completion: 0 = first free from any driven channel, 1 = free from every driven channel.
- TIMEOUT_CYCLES, 1024, WAIT_FREE cycle limit, used only with the optional feature.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- i_drive  in  1  upstream token request, sampled only in IDLE.
- o_free  out  1  high while in IDLE (ready for a token).
- o_fire  out  1  one-cycle pulse: token accepted, selection latched.
- i_valid  in  NUM_CH  per-channel condition, sampled with i_drive.
- o_driveNext  out  NUM_CH  one-cycle drive pulse to the selected channels.
- i_freeNext  in  NUM_CH  per-channel completion pulse/level.
- o_drop  out  1  one-cycle pulse: token accepted with no valid channel.
- o_timeout  out  1  one-cycle pulse on wait abort; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, async): state=IDLE, sel_q=0, pending=0, delay cnt=0, rr_ptr=0. Outputs: o_free=1, all others 0.
- States: IDLE, DELAY, WAIT_FREE.
- IDLE, cycle T with i_drive=1:
  - Compute sel from i_valid per MODE:
    - MODE0: sel=i_valid.
    - MODE1: lowest set bit only.
    - MODE2: first set bit at or after rr_ptr, wrapping at NUM_CH-1 -> 0.
  - Register sel_q; at T+1 o_fire=1 for one cycle.
  - If sel==0: o_drop=1 at T+1, state stays IDLE, o_free stays 1.
  - Otherwise: state -> DELAY, cnt=DRIVE_DELAY.
- IDLE with i_drive=0: no state change.
- DELAY: cnt decrements each cycle; at cnt==0 -> WAIT_FREE. With DRIVE_DELAY=0, DELAY lasts one cycle.
  - The first-drive cycle is therefore T+2+DRIVE_DELAY.
- WAIT_FREE:
  - First cycle: o_driveNext=sel_q (one-cycle pulse); pending=sel_q.
  - i_freeNext is sampled every WAIT_FREE cycle, including the first. Bits outside pending are ignored.
  - JOIN_ALL=0: any i_freeNext & pending -> IDLE next cycle.
  - JOIN_ALL=1: pending &= ~i_freeNext; -> IDLE when the updated pending==0, including when all bits clear in the same cycle.
- o_free = (state==IDLE), decoded from the state register. It deasserts at T+1 after an accepted non-drop token.
- i_drive in DELAY or WAIT_FREE is ignored; tokens are not queued. i_freeNext in IDLE or DELAY is ignored.
- rr_ptr: on each MODE2 grant to channel k, rr_ptr=(k+1) mod NUM_CH. It is unchanged on drop and unused in other modes.
- i_valid changes after sampling do not affect sel_q.
- Async reset mid-operation: immediate return to IDLE; an in-flight o_driveNext/o_fire pulse is cut; pending is discarded.

Optional Feature:
- Macro: CSEL_TIMEOUT_EN.
- Defined: a wait counter clears on WAIT_FREE entry and increments each WAIT_FREE cycle. If it reaches TIMEOUT_CYCLES before completion: o_timeout pulses 1 cycle, pending clears, and state -> IDLE. A free arriving in that same cycle takes priority, so there is no timeout.
- Undefined: no counter is built, o_timeout=0, and WAIT_FREE waits indefinitely.

Test Plan:
- Reset/idle: rst=0 then 1, no drive -> o_free=1; o_fire, o_driveNext, o_drop = 0 for 20 cycles.
- MODE0, NUM_CH=6, DRIVE_DELAY=8, i_valid=6'b100101, i_drive at T -> o_fire at T+1, o_driveNext=6'b100101 at T+10 only. i_freeNext[2] -> o_free=1 next cycle.
- JOIN_ALL=1, sel 6'b000011: free ch0 at cycle A, ch1 at A+3 -> o_free rises at A+4. Repeat with both free in one cycle -> o_free rises the next cycle.
- MODE2, i_valid=6'b111111, four tokens -> grants to ch0,1,2,3 in order. Then i_valid=6'b000001 -> grant ch0; rr_ptr=1.
- i_valid=0 with i_drive -> o_fire and o_drop pulse at T+1, o_driveNext stays 0, o_free stays 1. i_drive during WAIT_FREE -> ignored.
- CSEL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no free -> o_timeout pulses at the 16th WAIT_FREE cycle, then o_free=1. rst=0 mid-DELAY -> IDLE, no o_driveNext.
